// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: per-frame animation sequencer driven by the vsync strobe.
// A scene fades in, holds for scene_len frames, then fades out and advances to the
// next scene. Pause/step/next controls gate which vsync ticks advance the animation.
// Build option: define VGA_FRAME_SCHED_BOUNCE_EN to make frame a triangle wave
// instead of a sawtooth.
module vga_frame_scheduler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vsync_in,
   input  logic        ctrl_pause,
   input  logic        ctrl_step,
   input  logic        ctrl_next,
   input  logic [7:0]  scene_len,
   output logic [11:0] frame_count,
   output logic [7:0]  frame,
   output logic [1:0]  scene,
   output logic [1:0]  fade,
   output logic        upd
);

   typedef enum logic [1:0] {StFadeIn, StHold, StFadeOut} state_e;

   state_e      state_q, state_d;
   logic [1:0]  sub_q, sub_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        vsync_q;
   logic        step_q, next_q;
   logic        step_pend_q, step_pend_d;
   logic        next_pend_q, next_pend_d;
   logic [11:0] frame_count_q, frame_count_d;
   logic [7:0]  frame_q, frame_d;
   logic [1:0]  scene_q, scene_d;
   logic [1:0]  fade_q, fade_d;
   logic        upd_q, upd_d;

   logic        tick, adv, step_rise, next_rise;
   logic [7:0]  len_eff;

   // Edge detection, request latching and scene sequencing for the next edge.
   always_comb begin
      tick      = vsync_in & ~vsync_q;
      step_rise = ctrl_step & ~step_q;
      next_rise = ctrl_next & ~next_q;
      // A pending step lets exactly one tick through while paused.
      adv       = tick & (~ctrl_pause | step_pend_q);
      len_eff   = (scene_len == 8'd0) ? 8'd1 : scene_len;

      // A new edge wins over the clear so a request arriving with a tick is kept.
      step_pend_d = step_rise | (step_pend_q & ~adv);
      next_pend_d = next_rise | (next_pend_q & ~adv);

      state_d       = state_q;
      sub_d         = sub_q;
      hold_cnt_d    = hold_cnt_q;
      frame_count_d = frame_count_q;
      scene_d       = scene_q;
      fade_d        = fade_q;
      upd_d         = adv;

      if (adv) begin
         frame_count_d = frame_count_q + 12'd1;
         sub_d         = sub_q + 2'd1;
         unique case (state_q)
            StFadeIn: begin
               if (next_pend_q) begin
                  state_d = StFadeOut;
                  sub_d   = 2'd0;
               end else if (sub_q == 2'd3) begin
                  if (fade_q == 2'd3) begin
                     state_d    = StHold;
                     hold_cnt_d = len_eff;
                  end else begin
                     fade_d = fade_q + 2'd1;
                  end
               end
            end
            StHold: begin
               if (next_pend_q) begin
                  state_d = StFadeOut;
                  sub_d   = 2'd0;
               end else if (hold_cnt_q <= 8'd1) begin
                  hold_cnt_d = 8'd0;
                  state_d    = StFadeOut;
                  sub_d      = 2'd0;
               end else begin
                  hold_cnt_d = hold_cnt_q - 8'd1;
               end
            end
            StFadeOut: begin
               // A pending next is simply consumed here; the fade is already under way.
               if (sub_q == 2'd3) begin
                  if (fade_q == 2'd0) begin
                     scene_d = scene_q + 2'd1;
                     state_d = StFadeIn;
                     sub_d   = 2'd0;
                  end else begin
                     fade_d = fade_q - 2'd1;
                  end
               end
            end
            default: begin
               state_d = StFadeIn;
               sub_d   = 2'd0;
            end
         endcase
      end

`ifdef VGA_FRAME_SCHED_BOUNCE_EN
      frame_d = frame_count_d[8] ? ~frame_count_d[7:0] : frame_count_d[7:0];
`else
      frame_d = frame_count_d[7:0];
`endif
   end

   // Single state register; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StFadeIn;
         sub_q         <= 2'd0;
         hold_cnt_q    <= 8'd0;
         // Held high so a vsync already asserted at release is not seen as an edge.
         vsync_q       <= 1'b1;
         step_q        <= 1'b0;
         next_q        <= 1'b0;
         step_pend_q   <= 1'b0;
         next_pend_q   <= 1'b0;
         frame_count_q <= 12'd0;
         frame_q       <= 8'd0;
         scene_q       <= 2'd0;
         fade_q        <= 2'd0;
         upd_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         sub_q         <= sub_d;
         hold_cnt_q    <= hold_cnt_d;
         vsync_q       <= vsync_in;
         step_q        <= ctrl_step;
         next_q        <= ctrl_next;
         step_pend_q   <= step_pend_d;
         next_pend_q   <= next_pend_d;
         frame_count_q <= frame_count_d;
         frame_q       <= frame_d;
         scene_q       <= scene_d;
         fade_q        <= fade_d;
         upd_q         <= upd_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      frame_count = frame_count_q;
      frame       = frame_q;
      scene       = scene_q;
      fade        = fade_q;
      upd         = upd_q;
   end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Self-checking bench for vga_frame_scheduler: a phase/tick-count model of the
// scene sequence is compared against the DUT every cycle, plus literal checkpoints.
module tb_vga_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vsync_in;
   logic        ctrl_pause;
   logic        ctrl_step;
   logic        ctrl_next;
   logic [7:0]  scene_len;
   logic [11:0] frame_count;
   logic [7:0]  frame;
   logic [1:0]  scene;
   logic [1:0]  fade;
   logic        upd;

   int vec_cnt = 0;
   int err_cnt = 0;
   int upd_seen = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   vga_frame_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vsync_in    (vsync_in),
      .ctrl_pause  (ctrl_pause),
      .ctrl_step   (ctrl_step),
      .ctrl_next   (ctrl_next),
      .scene_len   (scene_len),
      .frame_count (frame_count),
      .frame       (frame),
      .scene       (scene),
      .fade        (fade),
      .upd         (upd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // phase 0 = fading in, 1 = holding, 2 = fading out; m_t counts advancing ticks in phase.
   int m_count, m_scene, m_phase, m_t, m_f0, m_hold;
   bit m_upd, m_vs_prev, m_st_prev, m_nx_prev, m_step_pend, m_next_pend;

   function automatic int exp_frame(input int c);
`ifdef VGA_FRAME_SCHED_BOUNCE_EN
      return ((c & 256) != 0) ? (~c & 255) : (c & 255);
`else
      return c & 255;
`endif
   endfunction

   function automatic int exp_fade();
      if (m_phase == 0) return m_t / 4;
      if (m_phase == 1) return 3;
      return m_f0 - m_t / 4;
   endfunction

   task automatic model_advance(input bit nx);
      m_count = (m_count + 1) % 4096;
      case (m_phase)
         0: begin
            if (nx) begin
               m_f0 = m_t / 4; m_t = 0; m_phase = 2;
            end else begin
               m_t++;
               if (m_t == 16) begin
                  m_phase = 1; m_t = 0;
                  m_hold = (scene_len == 8'd0) ? 1 : int'(scene_len);
               end
            end
         end
         1: begin
            if (nx) begin
               m_f0 = 3; m_t = 0; m_phase = 2;
            end else begin
               m_t++;
               if (m_t >= m_hold) begin
                  m_f0 = 3; m_t = 0; m_phase = 2;
               end
            end
         end
         default: begin
            m_t++;
            if (m_t == 4 * (m_f0 + 1)) begin
               m_scene = (m_scene + 1) % 4; m_phase = 0; m_t = 0;
            end
         end
      endcase
   endtask

   always @(posedge clk) begin : model
      bit tk, adv;
      if (!rst_n) begin
         m_count = 0; m_scene = 0; m_phase = 0; m_t = 0; m_f0 = 0; m_hold = 0;
         m_upd = 0; m_vs_prev = 1; m_st_prev = 0; m_nx_prev = 0;
         m_step_pend = 0; m_next_pend = 0;
      end else begin
         tk    = vsync_in && !m_vs_prev;
         adv   = tk && (!ctrl_pause || m_step_pend);
         m_upd = adv;
         if (adv) begin
            model_advance(m_next_pend);
            m_step_pend = 0;
            m_next_pend = 0;
         end
         if (ctrl_step && !m_st_prev) m_step_pend = 1;
         if (ctrl_next && !m_nx_prev) m_next_pend = 1;
         m_vs_prev = vsync_in;
         m_st_prev = ctrl_step;
         m_nx_prev = ctrl_next;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("frame_count", 32'(frame_count), m_count);
         check("frame", 32'(frame), exp_frame(m_count));
         check("scene", 32'(scene), m_scene);
         check("fade", 32'(fade), exp_fade());
         check("upd", 32'(upd), 32'(m_upd));
      end
   end

   always @(negedge clk) if (rst_n === 1'b1 && upd === 1'b1) upd_seen++;

   // ---------------- stimulus ----------------
   task automatic vsync_pulse();
      vsync_in = 1'b1;
      repeat (2) @(negedge clk);
      vsync_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) vsync_pulse();
   endtask

   task automatic pulse_step();
      ctrl_step = 1'b1; @(negedge clk);
      ctrl_step = 1'b0; @(negedge clk);
   endtask

   task automatic pulse_next();
      ctrl_next = 1'b1; @(negedge clk);
      ctrl_next = 1'b0; @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; vsync_in = 1'b0; ctrl_pause = 1'b0; ctrl_step = 1'b0;
      ctrl_next = 1'b0; scene_len = 8'd5;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_count", 32'(frame_count), 0);
      check("rst_frame", 32'(frame), 0);
      check("rst_scene", 32'(scene), 0);
      check("rst_fade", 32'(fade), 0);
      check("rst_upd", 32'(upd), 0);

      // Basic sequence with scene_len = 5.
      rst_n = 1'b1;
      @(negedge clk);
      upd_seen = 0;
      ticks(11); check("s1_fade_t11", 32'(fade), 2);
      ticks(1);  check("s1_fade_t12", 32'(fade), 3);
      ticks(8);
      check("s1_count_t20", 32'(frame_count), 20);
      check("s1_upd_pulses", upd_seen, 20);
      check("s1_fade_t20", 32'(fade), 3);
      ticks(16); check("s1_scene_t36", 32'(scene), 0);
      ticks(1);  check("s1_scene_t37", 32'(scene), 1);
      check("s1_fade_t37", 32'(fade), 0);

      // Pause and step.
      ctrl_pause = 1'b1;
      upd_seen = 0;
      ticks(10);
      check("s2_paused_count", 32'(frame_count), 37);
      check("s2_paused_upd", upd_seen, 0);
      pulse_step(); ticks(1); check("s2_step1", 32'(frame_count), 38);
      pulse_step(); ticks(1); check("s2_step2", 32'(frame_count), 39);
      ticks(1); check("s2_nostep", 32'(frame_count), 39);
      // Step edge coinciding with a tick is held for the following tick.
      vsync_in = 1'b1; ctrl_step = 1'b1;
      @(negedge clk);
      ctrl_step = 1'b0;
      @(negedge clk);
      vsync_in = 1'b0;
      repeat (3) @(negedge clk);
      check("s2_coincide", 32'(frame_count), 39);
      ticks(1); check("s2_coincide_late", 32'(frame_count), 40);
      ticks(1); check("s2_after_step", 32'(frame_count), 40);
      // Next waits while paused.
      pulse_next(); ticks(3);
      check("s2_next_paused", 32'(frame_count), 40);
      check("s2_next_paused_scene", 32'(scene), 1);
      ctrl_pause = 1'b0;
      ticks(4); check("s2_next_out", 32'(scene), 1);
      ticks(1); check("s2_next_scene", 32'(scene), 2);
      check("s2_count", 32'(frame_count), 45);

      // Next during HOLD at full brightness.
      scene_len = 8'd200;
      do_reset();
      ticks(16); check("s3_hold_fade", 32'(fade), 3);
      pulse_next();
      ticks(1);  check("s3_out_fade", 32'(fade), 3);
      ticks(4);  check("s3_out_fade2", 32'(fade), 2);
      ticks(11); check("s3_out_scene", 32'(scene), 0);
      check("s3_out_fade0", 32'(fade), 0);
      ticks(1);  check("s3_new_scene", 32'(scene), 1);
      check("s3_count", 32'(frame_count), 33);

      // scene_len changes mid-HOLD do not shorten it; 0 is later loaded as 1.
      scene_len = 8'd3;
      ticks(16);
      scene_len = 8'd0;
      ticks(6); check("s3_len_fade_55", 32'(fade), 3);
      ticks(1); check("s3_len_fade_56", 32'(fade), 2);
      ticks(32); check("s3_len0_fade_88", 32'(fade), 3);
      check("s3_len0_scene", 32'(scene), 2);
      ticks(1); check("s3_len0_fade_89", 32'(fade), 2);

      // Reset mid fade-out with vsync held high through release.
      rst_n = 1'b0; vsync_in = 1'b1;
      @(negedge clk);
      check("s4_rst_count", 32'(frame_count), 0);
      check("s4_rst_scene", 32'(scene), 0);
      check("s4_rst_fade", 32'(fade), 0);
      check("s4_rst_frame", 32'(frame), 0);
      rst_n = 1'b1;
      upd_seen = 0;
      repeat (5) @(negedge clk);
      check("s4_rel_count", 32'(frame_count), 0);
      check("s4_rel_upd", upd_seen, 0);
      vsync_in = 1'b0;
      repeat (2) @(negedge clk);
      ticks(1); check("s4_first_tick", 32'(frame_count), 1);

      // Long run through the counter wrap, with occasional next requests.
      scene_len = 8'd7;
      ticks(254);
      check("s5_frame_255", 32'(frame), exp_frame(255));
      check("s5_frame_255_lit", 32'(frame), 255);
      ticks(1);
`ifdef VGA_FRAME_SCHED_BOUNCE_EN
      check("s5_frame_256_lit", 32'(frame), 255);
      ticks(1); check("s5_frame_257_lit", 32'(frame), 254);
`else
      check("s5_frame_256_lit", 32'(frame), 0);
      ticks(1); check("s5_frame_257_lit", 32'(frame), 1);
`endif
      for (int i = 0; i < 3839; i++) begin
         if (i % 37 == 5) pulse_next();
         vsync_pulse();
      end
      check("s5_wrap_count", 32'(frame_count), 0);
      check("s5_wrap_frame", 32'(frame), 0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
